// File: rtl/rans_lane_sched.sv
// Sequencer/arbiter for a NUM_LANES-wide rANS encoder array: table broadcast,
// round-robin symbol dispatch, per-lane byte holds and a lane-tagged output merge.
module rans_lane_sched #(
  parameter int unsigned NUM_LANES    = 4,
  parameter int unsigned SYMBOL_WIDTH = 8,
  parameter int unsigned RESOLUTION   = 10,
  parameter int unsigned DRAIN_CYCLES = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         cfg_start_i,
  input  logic                         cfg_valid_i,
  output logic                         cfg_ready_o,
  input  logic [SYMBOL_WIDTH-1:0]      cfg_symb_i,
  input  logic [RESOLUTION-1:0]        cfg_freq_i,
  input  logic [RESOLUTION-1:0]        cfg_cum_freq_i,
  input  logic                         cfg_last_i,
  input  logic                         s_valid_i,
  output logic                         s_ready_o,
  input  logic [SYMBOL_WIDTH-1:0]      s_symb_i,
  input  logic                         s_last_i,
  output logic [NUM_LANES-1:0]         lane_en_o,
  output logic                         lane_freq_wr_o,
  output logic [SYMBOL_WIDTH-1:0]      lane_symb_o,
  output logic [RESOLUTION-1:0]        lane_freq_o,
  output logic [RESOLUTION-1:0]        lane_cum_freq_o,
  input  logic [NUM_LANES-1:0]         lane_valid_i,
  input  logic [8*NUM_LANES-1:0]       lane_enc_i,
  output logic                         m_valid_o,
  input  logic                         m_ready_i,
  output logic [7:0]                   m_data_o,
  output logic [$clog2(NUM_LANES)-1:0] m_lane_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o
);

  localparam int unsigned LW = $clog2(NUM_LANES);
  localparam int unsigned CW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [NUM_LANES-1:0]  ONE_LANE   = NUM_LANES'(1);
  localparam logic [RESOLUTION:0]   FREQ_TOTAL = {1'b1, {RESOLUTION{1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_FLUSH} state_t;

  state_t               state, state_nx;
  logic [LW-1:0]        dptr, optr;
  logic [NUM_LANES-1:0] hold_full;
  logic [7:0]           hold_data [NUM_LANES];
  logic [CW-1:0]        quiet_cnt;

  logic                 cfg_acc, s_acc, m_hs, m_load, quiet, flush_go, freq_ovf;
  logic [RESOLUTION:0]  freq_sum;
  logic [NUM_LANES-1:0] drain_mask, eligible;
  logic [LW-1:0]        search_base, idx, grant;
  logic                 grant_any;

  assign cfg_ready_o = (state == ST_LOAD);
  assign s_ready_o   = (state == ST_RUN) & ~hold_full[dptr];
  assign busy_o      = (state != ST_IDLE);

  assign cfg_acc  = cfg_ready_o & cfg_valid_i;
  assign s_acc    = s_valid_i & s_ready_o;
  assign m_hs     = m_valid_o & m_ready_i;
  assign m_load   = ~m_valid_o | m_ready_i;
  assign freq_sum = {1'b0, cfg_freq_i} + {1'b0, cfg_cum_freq_i};
  assign freq_ovf = (freq_sum > FREQ_TOTAL);

  assign drain_mask = m_hs ? (ONE_LANE << m_lane_o) : '0;
  assign quiet      = (lane_valid_i == '0) & (hold_full == '0);
  assign flush_go   = (state == ST_FLUSH) & quiet & (quiet_cnt == CW'(DRAIN_CYCLES - 1));

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (cfg_start_i)          state_nx = ST_LOAD;
      ST_LOAD:  if (cfg_acc & cfg_last_i) state_nx = ST_RUN;
      ST_RUN:   if (s_acc & s_last_i)     state_nx = ST_FLUSH;
      ST_FLUSH: if (flush_go)             state_nx = ST_IDLE;
      default:                            state_nx = ST_IDLE;
    endcase
  end

  // The lane being handed off this cycle is excluded so the next grant can
  // be registered in the same cycle as the handshake (no bubble).
  always_comb begin
    eligible    = hold_full & ~drain_mask;
    search_base = m_hs ? (m_lane_o + LW'(1)) : optr;
    grant_any   = 1'b0;
    grant       = '0;
    idx         = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      idx = search_base + LW'(i);
      if (!grant_any && eligible[idx]) begin
        grant_any = 1'b1;
        grant     = idx;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state           <= ST_IDLE;
      dptr            <= '0;
      optr            <= '0;
      hold_full       <= '0;
      for (int unsigned k = 0; k < NUM_LANES; k++) hold_data[k] <= '0;
      quiet_cnt       <= '0;
      lane_en_o       <= '0;
      lane_freq_wr_o  <= 1'b0;
      lane_symb_o     <= '0;
      lane_freq_o     <= '0;
      lane_cum_freq_o <= '0;
      m_valid_o       <= 1'b0;
      m_data_o        <= '0;
      m_lane_o        <= '0;
      done_o          <= 1'b0;
      err_o           <= 1'b0;
    end else begin
      state          <= state_nx;
      done_o         <= flush_go;
      lane_en_o      <= '0;
      lane_freq_wr_o <= 1'b0;

      if (cfg_acc) begin
        lane_freq_wr_o  <= 1'b1;
        lane_symb_o     <= cfg_symb_i;
        lane_freq_o     <= cfg_freq_i;
        lane_cum_freq_o <= cfg_cum_freq_i;
        if (freq_ovf) err_o <= 1'b1;
      end

      if (s_acc) begin
        lane_en_o   <= ONE_LANE << dptr;
        lane_symb_o <= s_symb_i;
        dptr        <= dptr + LW'(1);
      end

      for (int unsigned k = 0; k < NUM_LANES; k++) begin
        if (lane_valid_i[k]) begin
          if (hold_full[k] && !drain_mask[k]) begin
            err_o <= 1'b1;
          end else begin
            hold_data[k] <= lane_enc_i[8*k +: 8];
            hold_full[k] <= 1'b1;
          end
        end else if (drain_mask[k]) begin
          hold_full[k] <= 1'b0;
        end
      end

      if (m_hs) optr <= m_lane_o + LW'(1);
      if (m_load) begin
        m_valid_o <= grant_any;
        if (grant_any) begin
          m_data_o <= hold_data[grant];
          m_lane_o <= grant;
        end
      end

      if (state != ST_FLUSH || !quiet) quiet_cnt <= '0;
      else if (quiet_cnt != CW'(DRAIN_CYCLES)) quiet_cnt <= quiet_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_rans_lane_sched.sv
// Directed + randomized bench for rans_lane_sched; lanes and the expected
// output stream are modelled at transaction level inside the bench.
module tb_rans_lane_sched;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        cfg_start_i, cfg_valid_i, cfg_last_i, cfg_ready_o;
  logic [7:0]  cfg_symb_i;
  logic [9:0]  cfg_freq_i, cfg_cum_freq_i;
  logic        s_valid_i, s_ready_o, s_last_i;
  logic [7:0]  s_symb_i;
  logic [3:0]  lane_en_o;
  logic        lane_freq_wr_o;
  logic [7:0]  lane_symb_o;
  logic [9:0]  lane_freq_o, lane_cum_freq_o;
  logic [3:0]  lane_valid_i;
  logic [31:0] lane_enc_i;
  logic        m_valid_o, m_ready_i;
  logic [7:0]  m_data_o;
  logic [1:0]  m_lane_o;
  logic        busy_o, done_o, err_o;

  rans_lane_sched #(
    .NUM_LANES(4), .SYMBOL_WIDTH(8), .RESOLUTION(10), .DRAIN_CYCLES(8)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cfg_start_i(cfg_start_i), .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .cfg_symb_i(cfg_symb_i), .cfg_freq_i(cfg_freq_i), .cfg_cum_freq_i(cfg_cum_freq_i),
    .cfg_last_i(cfg_last_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_symb_i(s_symb_i), .s_last_i(s_last_i),
    .lane_en_o(lane_en_o), .lane_freq_wr_o(lane_freq_wr_o), .lane_symb_o(lane_symb_o),
    .lane_freq_o(lane_freq_o), .lane_cum_freq_o(lane_cum_freq_o),
    .lane_valid_i(lane_valid_i), .lane_enc_i(lane_enc_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o), .m_lane_o(m_lane_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef enum {M_IDLE, M_LOAD, M_RUN, M_FLUSH} mst_t;
  typedef struct packed { logic [1:0] lane; logic [7:0] data; } ent_t;

  int   n_vec = 0, n_bad = 0;
  mst_t exp_state = M_IDLE;
  int   dptr_m = 0, qcnt = 0, edge_n = 0, last_hs_edge = -1, done_edge = -1;
  logic [3:0] occ = '0;
  bit   exp_err = 1'b0, sym_silent = 1'b0, last_s_acc = 1'b0;
  ent_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic timeout(input string tag);
    n_vec++;
    n_bad++;
    $error("FAIL %s: bound expired, observed timeout expected completion", tag);
  endtask

  // One clock: predict from current inputs, cross the edge, compare, drive lanes.
  task automatic cycle();
    bit rst_now, cfg_acc, s_acc, hs, hold_m, go, start_now, c_last, s_last, silent;
    int s_lane;
    logic [7:0] s_sym, c_sym, sv_data, b;
    logic [9:0] c_f, c_c;
    logic [1:0] sv_lane;
    logic [3:0] capm, hsm;
    ent_t e;
    rst_now = !rst_ni;
    if (!rst_now) begin
      chk("s_ready", s_ready_o, (exp_state == M_RUN) && !occ[dptr_m]);
      chk("cfg_ready", cfg_ready_o, exp_state == M_LOAD);
      chk("busy", busy_o, exp_state != M_IDLE);
    end
    start_now = cfg_start_i;
    cfg_acc = !rst_now && exp_state == M_LOAD && cfg_valid_i;
    s_acc   = !rst_now && exp_state == M_RUN && !occ[dptr_m] && s_valid_i;
    hs      = !rst_now && m_valid_o && m_ready_i;
    hold_m  = !rst_now && m_valid_o && !m_ready_i;
    capm    = rst_now ? 4'b0 : lane_valid_i;
    c_sym = cfg_symb_i; c_f = cfg_freq_i; c_c = cfg_cum_freq_i; c_last = cfg_last_i;
    s_sym = s_symb_i; s_last = s_last_i; s_lane = dptr_m; silent = sym_silent;
    sv_data = m_data_o; sv_lane = m_lane_o;
    hsm = '0;
    if (hs) begin
      last_hs_edge = edge_n + 1;
      if (exp_q.size() == 0) chk("m_spurious", m_valid_o, 0);
      else begin
        e = exp_q.pop_front();
        chk("m_lane", m_lane_o, e.lane);
        chk("m_data", m_data_o, e.data);
        hsm[e.lane] = 1'b1;
      end
    end
    go = 1'b0;
    if (!rst_now && exp_state == M_FLUSH) begin
      if (lane_valid_i == 4'b0 && occ == 4'b0) qcnt++; else qcnt = 0;
      go = (qcnt == 8);
    end

    @(negedge clk_i);
    edge_n++;

    if (rst_now) begin
      exp_state = M_IDLE; dptr_m = 0; occ = '0; exp_q.delete(); exp_err = 0; qcnt = 0;
      chk("rst_lane_en", lane_en_o, 0);       chk("rst_freq_wr", lane_freq_wr_o, 0);
      chk("rst_lane_symb", lane_symb_o, 0);   chk("rst_lane_freq", lane_freq_o, 0);
      chk("rst_lane_cum", lane_cum_freq_o, 0); chk("rst_m_valid", m_valid_o, 0);
      chk("rst_m_data", m_data_o, 0);         chk("rst_m_lane", m_lane_o, 0);
      chk("rst_done", done_o, 0);             chk("rst_err", err_o, 0);
      chk("rst_busy", busy_o, 0);             chk("rst_cfg_ready", cfg_ready_o, 0);
      chk("rst_s_ready", s_ready_o, 0);
    end else begin
      occ = (occ & ~hsm) | capm;
      case (exp_state)
        M_IDLE:  if (start_now) exp_state = M_LOAD;
        M_LOAD:  if (cfg_acc) begin
                   if (int'(c_f) + int'(c_c) > 1024) exp_err = 1'b1;
                   if (c_last) exp_state = M_RUN;
                 end
        M_RUN:   if (s_acc) begin
                   dptr_m = (dptr_m + 1) % 4;
                   if (s_last) begin exp_state = M_FLUSH; qcnt = 0; end
                 end
        M_FLUSH: if (go) exp_state = M_IDLE;
        default: ;
      endcase
      chk("freq_wr", lane_freq_wr_o, cfg_acc);
      if (cfg_acc) begin
        chk("tbl_symb", lane_symb_o, c_sym);
        chk("tbl_freq", lane_freq_o, c_f);
        chk("tbl_cum", lane_cum_freq_o, c_c);
      end
      chk("lane_en", lane_en_o, s_acc ? (32'd1 << s_lane) : 32'd0);
      if (s_acc) chk("lane_symb", lane_symb_o, s_sym);
      chk("err", err_o, exp_err);
      chk("done", done_o, go);
      if (hold_m) begin
        chk("m_hold_valid", m_valid_o, 1);
        chk("m_hold_data", m_data_o, sv_data);
        chk("m_hold_lane", m_lane_o, sv_lane);
      end
      if (done_o === 1'b1) done_edge = edge_n;
    end
    last_s_acc = s_acc;

    lane_valid_i = '0;
    lane_enc_i   = $urandom;
    if (s_acc && !silent) begin
      b = 8'($urandom);
      lane_valid_i[s_lane] = 1'b1;
      lane_enc_i[8*s_lane +: 8] = b;
      exp_q.push_back('{lane: 2'(s_lane), data: b});
    end
  endtask

  task automatic cfg_entry(input logic [7:0] sym, input logic [9:0] f, input logic [9:0] c, input bit last);
    cfg_valid_i = 1'b1; cfg_symb_i = sym; cfg_freq_i = f; cfg_cum_freq_i = c; cfg_last_i = last;
    cycle();
    cfg_valid_i = 1'b0; cfg_last_i = 1'b0; cfg_freq_i = 10'($urandom); cfg_cum_freq_i = 10'($urandom);
  endtask

  task automatic load_table();
    cfg_start_i = 1'b1; cycle(); cfg_start_i = 1'b0;
    cfg_entry(8'd0, 10'd512, 10'd0, 1'b0);
    cfg_entry(8'd1, 10'd256, 10'd512, 1'b0);
    cfg_entry(8'd2, 10'd256, 10'd768, 1'b1);
  endtask

  task automatic send_sym(input logic [7:0] sym, input bit last, input bit quiet);
    int n = 0;
    s_valid_i = 1'b1; s_symb_i = sym; s_last_i = last; sym_silent = quiet;
    do begin cycle(); n++; end while (!last_s_acc && n < 50);
    s_valid_i = 1'b0; s_last_i = 1'b0; sym_silent = 1'b0;
    if (!last_s_acc) timeout("send_sym");
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || occ != 4'b0) && n < 200) begin cycle(); n++; end
    if (exp_q.size() != 0 || occ != 4'b0) timeout("drain");
    cycle();
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; cycle(); cycle(); rst_ni = 1'b1; cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst_ni = 1'b0; cfg_start_i = 0; cfg_valid_i = 0; cfg_last_i = 0;
    cfg_symb_i = 0; cfg_freq_i = 0; cfg_cum_freq_i = 0;
    s_valid_i = 0; s_symb_i = 0; s_last_i = 0;
    lane_valid_i = 0; lane_enc_i = 0; m_ready_i = 0;

    // 1: reset, table load, boundary sum == 1024 gives no error
    do_reset();
    load_table();
    cycle();
    chk("t1_run_s_ready", s_ready_o, 1);
    chk("t1_err", err_o, 0);

    // 2: overflowing entry sets sticky error; cfg_start ignored outside IDLE
    do_reset();
    cfg_start_i = 1'b1; cycle(); cfg_start_i = 1'b0;
    cfg_entry(8'd5, 10'd600, 10'd512, 1'b1);
    cfg_start_i = 1'b1; cycle(); cfg_start_i = 1'b0;
    repeat (6) cycle();
    chk("t2_err_sticky", err_o, 1);
    chk("t2_cfg_ignored", cfg_ready_o, 0);
    do_reset();
    chk("t2_err_cleared", err_o, 0);

    // 3: nine symbols, free-flowing output
    load_table();
    m_ready_i = 1'b1;
    for (int i = 0; i < 9; i++) send_sym(8'($urandom), 1'b0, 1'b0);
    drain();

    // randomized traffic with output back-pressure
    for (int i = 0; i < 60; i++) begin
      s_valid_i = ($urandom_range(0, 3) != 0);
      s_symb_i  = 8'($urandom);
      m_ready_i = ($urandom_range(0, 2) != 0);
      cycle();
    end
    s_valid_i = 1'b0; m_ready_i = 1'b1;
    drain();

    // 4: output stalled for 20 cycles; only four symbols fit in the holds
    m_ready_i = 1'b0; s_valid_i = 1'b1;
    for (int i = 0; i < 20; i++) begin s_symb_i = 8'($urandom); cycle(); end
    chk("t4_s_ready_low", s_ready_o, 0);
    chk("t4_m_valid", m_valid_o, 1);
    chk("t4_no_err", err_o, 0);
    s_valid_i = 1'b0; m_ready_i = 1'b1;
    drain();

    // 5: last symbol with silent lanes, done 8 cycles after final drain
    m_ready_i = 1'b0;
    send_sym(8'($urandom), 1'b0, 1'b0);
    send_sym(8'($urandom), 1'b0, 1'b0);
    repeat (4) cycle();
    send_sym(8'($urandom), 1'b1, 1'b1);
    repeat (3) cycle();
    m_ready_i = 1'b1;
    drain();
    done_edge = -1;
    for (int n = 0; n < 40 && done_edge < 0; n++) cycle();
    if (done_edge < 0) timeout("t5_done");
    else chk("t5_done_gap", 32'(done_edge - last_hs_edge), 8);
    cycle();
    chk("t5_idle_busy", busy_o, 0);

    // 6: reset mid-RUN with holds full, then symbols ignored
    load_table();
    m_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) send_sym(8'($urandom), 1'b0, 1'b0);
    repeat (3) cycle();
    chk("t6_holding", m_valid_o, 1);
    rst_ni = 1'b0; cycle(); rst_ni = 1'b1;
    s_valid_i = 1'b1;
    repeat (4) cycle();
    s_valid_i = 1'b0;
    chk("t6_lane_en_idle", lane_en_o, 0);
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
